// File: rtl/alu_issue.sv
// Issue/response sequencer for a single-cycle ALU with registered flags.
// Accepts one operation at a time, drives the ALU, and holds the captured result until taken.
module alu_issue #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [31:0]      req_op1_i,
   input  logic [31:0]      req_op2_i,
   input  logic [3:0]       req_oprt_i,
   output logic [31:0]      alu_op1_o,
   output logic [31:0]      alu_op2_o,
   output logic [3:0]       alu_oprt_o,
   output logic             alu_en_o,
   input  logic [31:0]      alu_res_i,
   input  logic [10:0]      alu_flag_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_res_o,
   output logic [3:0]       rsp_flag_o,
   output logic             rsp_err_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] op_count_o
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OPRT_W = 4;
   localparam int unsigned FLAG_W = 4;
   localparam logic [DATA_W-1:0] ERR_RES = DATA_W'(32'h8000_0000);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      FLAG = 2'd2,
      RESP = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic [OPRT_W-1:0]   oprt_q, oprt_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [FLAG_W-1:0]   flag_q, flag_d;
   logic                err_q, err_d;
   logic                alu_en_q, alu_en_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                accept;

   // Only N/Z/C/V are consumed; the remaining ALU flag bits are ignored.
   logic unused_flag_bits;
   assign unused_flag_bits = ^alu_flag_i[10:FLAG_W];

   function automatic logic op_supported(input logic [OPRT_W-1:0] oprt);
      return !(oprt inside {4'b0010, 4'b0011, 4'b1110, 4'b1111});
   endfunction

   // Ready in IDLE, or when the held response is being taken this cycle.
   assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      state_d  = state_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      oprt_d   = oprt_q;
      res_d    = res_q;
      flag_d   = flag_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      alu_en_d = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;

      unique case (state_q)
         IDLE: ;
         EXEC: begin
            res_d   = alu_res_i;
            state_d = FLAG;
         end
         FLAG: begin
            flag_d  = alu_flag_i[FLAG_W-1:0];
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new accept overrides the IDLE return of a completing response.
      if (accept) begin
         op1_d  = req_op1_i;
         op2_d  = req_op2_i;
         oprt_d = req_oprt_i;
         if (op_supported(req_oprt_i)) begin
            state_d = EXEC;
         end else begin
            res_d   = ERR_RES;
            flag_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
         end
      end

      alu_en_d = (state_d == EXEC) || (state_d == FLAG);
      valid_d  = (state_d == RESP);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op1_q    <= '0;
         op2_q    <= '0;
         oprt_q   <= '0;
         res_q    <= '0;
         flag_q   <= '0;
         err_q    <= 1'b0;
         alu_en_q <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         oprt_q   <= oprt_d;
         res_q    <= res_d;
         flag_q   <= flag_d;
         err_q    <= err_d;
         alu_en_q <= alu_en_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign alu_op1_o   = op1_q;
   assign alu_op2_o   = op2_q;
   assign alu_oprt_o  = oprt_q;
   assign alu_en_o    = alu_en_q;
   assign rsp_valid_o = valid_q;
   assign rsp_res_o   = res_q;
   assign rsp_flag_o  = flag_q;
   assign rsp_err_o   = err_q;
   assign busy_o      = busy_q;
   assign op_count_o  = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU and a response scoreboard.
module tb_alu_issue;

   localparam int unsigned CNT_W = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flag;
      logic        err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_op1, req_op2;
   logic [3:0]       req_oprt;
   logic [31:0]      alu_op1, alu_op2;
   logic [3:0]       alu_oprt;
   logic             alu_en;
   logic [31:0]      alu_res;
   logic [10:0]      alu_flag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_res;
   logic [3:0]       rsp_flag;
   logic             rsp_err;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt = 0;
   int   alu_en_cnt = 0;
   exp_t sb[$];
   exp_t m_out;

   always #5 clk = ~clk;

   alu_issue #(.CNT_W(CNT_W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op1_i   (req_op1),
      .req_op2_i   (req_op2),
      .req_oprt_i  (req_oprt),
      .alu_op1_o   (alu_op1),
      .alu_op2_o   (alu_op2),
      .alu_oprt_o  (alu_oprt),
      .alu_en_o    (alu_en),
      .alu_res_i   (alu_res),
      .alu_flag_i  (alu_flag),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_res_o   (rsp_res),
      .rsp_flag_o  (rsp_flag),
      .rsp_err_o   (rsp_err),
      .busy_o      (busy),
      .op_count_o  (op_count)
   );

   function automatic exp_t mk(input logic [31:0] r, input logic [3:0] f, input logic e);
      exp_t x;
      x.res = r; x.flag = f; x.err = e;
      return x;
   endfunction

   // Behavioural ALU: flags returned as {V,C,Z,N}.
   function automatic exp_t alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
      logic [32:0] w;
      logic [31:0] r;
      logic c, v;
      c = 1'b0; v = 1'b0; w = '0;
      case (o)
         4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                     v = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; c = w[32];
                     v = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = a ^ b;
         4'd7:  r = a << b[4:0];
         4'd8:  r = a >> b[4:0];
         4'd9:  r = $unsigned($signed(a) >>> b[4:0]);
         4'd10: r = ~(a & b);
         4'd11: r = ~(a | b);
         4'd12: r = ~a;
         default: r = b;
      endcase
      return mk(r, {v, c, (r == 32'd0), r[31]}, 1'b0);
   endfunction

   always_comb m_out = alu_model(alu_op1, alu_op2, alu_oprt);
   assign alu_res = m_out.res;

   // Flags are registered by the ALU; upper bits carry junk that must be ignored.
   always @(posedge clk) begin
      if (alu_en) begin
         alu_flag   <= {7'h5A, m_out.flag};
         alu_en_cnt <= alu_en_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o,
                        input bit push, input exp_t e);
      int w;
      req_op1 = a; req_op2 = b; req_oprt = o; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 20) begin tick(); w++; end
      chk("issue_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      if (push) sb.push_back(e);
   endtask

   task automatic wait_rsp(input int lat, input string tag);
      int n;
      exp_t e;
      n = 0;
      while (!rsp_valid && n < 10) begin tick(); n++; end
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      if (sb.size() == 0) begin
         n_tests++; n_fail++;
         $error("FAIL %s_sb: observed response expected none queued", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_res"}, rsp_res, e.res);
         chk({tag, "_flag"}, 32'(rsp_flag), 32'(e.flag));
         chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      end
   endtask

   task automatic take(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % CNT_MOD;
      chk({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
      chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int en0;
      logic [3:0] ops [12];
      logic [31:0] a, b;
      logic [3:0] o;
      ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op1 = '0; req_op2 = '0; req_oprt = '0;
      repeat (2) tick();
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_en", 32'(alu_en), 32'd0);
      chk("rst_cnt", 32'(op_count), 32'd0);
      chk("rst_res", rsp_res, 32'd0);
      chk("rst_op1", alu_op1, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(req_ready), 32'd1);

      // ADD 5+3
      issue(32'd5, 32'd3, 4'd0, 1'b1, mk(32'h0000_0008, 4'b0000, 1'b0));
      chk("exec_alu_en", 32'(alu_en), 32'd1);
      chk("exec_op1", alu_op1, 32'd5);
      chk("exec_op2", alu_op2, 32'd3);
      chk("exec_busy", 32'(busy), 32'd1);
      wait_rsp(2, "add");
      chk("resp_alu_en", 32'(alu_en), 32'd0);
      take("add");

      issue(32'd3, 32'd5, 4'd1, 1'b1, mk(32'hFFFF_FFFE, 4'b0001, 1'b0));
      wait_rsp(2, "sub");
      take("sub");

      issue(32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 1'b1, mk(32'h8000_0000, 4'b1001, 1'b0));
      wait_rsp(2, "ovf");
      take("ovf");

      // Unsupported opcodes go straight to a response without enabling the ALU.
      en0 = alu_en_cnt;
      issue(32'd11, 32'd22, 4'b1110, 1'b1, mk(32'h8000_0000, 4'b0000, 1'b1));
      wait_rsp(0, "unsup_e");
      chk("unsup_oprt", 32'(alu_oprt), 32'hE);
      take("unsup_e");
      issue(32'd1, 32'd2, 4'b0010, 1'b1, mk(32'h8000_0000, 4'b0000, 1'b1));
      wait_rsp(0, "unsup_2");
      take("unsup_2");
      issue(32'd1, 32'd2, 4'b0011, 1'b1, mk(32'h8000_0000, 4'b0000, 1'b1));
      wait_rsp(0, "unsup_3");
      take("unsup_3");
      issue(32'd1, 32'd2, 4'b1111, 1'b1, mk(32'h8000_0000, 4'b0000, 1'b1));
      wait_rsp(0, "unsup_f");
      take("unsup_f");
      chk("unsup_no_alu_en", 32'(alu_en_cnt - en0), 32'd0);

      // Backpressure, then same-edge handshake and accept.
      issue(32'd100, 32'd23, 4'd0, 1'b1, mk(32'd123, 4'b0000, 1'b0));
      wait_rsp(2, "hold");
      req_op1 = 32'd7; req_op2 = 32'd9; req_oprt = 4'd0; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_ready", 32'(req_ready), 32'd0);
         chk("hold_res", rsp_res, 32'd123);
         tick();
      end
      chk("hold_busy", 32'(busy), 32'd1);
      rsp_ready = 1'b1;
      #1;
      chk("b2b_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b0; req_valid = 1'b0;
      exp_cnt = (exp_cnt + 1) % CNT_MOD;
      sb.push_back(mk(32'd16, 4'b0000, 1'b0));
      chk("b2b_cnt", 32'(op_count), 32'(exp_cnt));
      chk("b2b_valid", 32'(rsp_valid), 32'd0);
      chk("b2b_exec", 32'(alu_en), 32'd1);
      chk("b2b_op1", alu_op1, 32'd7);
      wait_rsp(2, "b2b");
      take("b2b");

      // Reset while in FLAG discards the operation.
      issue(32'd1, 32'd2, 4'd0, 1'b0, mk(32'd0, 4'd0, 1'b0));
      tick();
      chk("flag_alu_en", 32'(alu_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_alu_en", 32'(alu_en), 32'd0);
      chk("arst_res", rsp_res, 32'd0);
      chk("arst_op1", alu_op1, 32'd0);
      chk("arst_cnt", 32'(op_count), 32'd0);
      exp_cnt = 0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end

      // Count up to all-ones, then wrap.
      for (int i = 0; i < CNT_MOD - 1; i++) begin
         issue(32'(i), 32'd0, 4'b1111, 1'b1, mk(32'h8000_0000, 4'b0000, 1'b1));
         wait_rsp(0, "fill");
         take("fill");
      end
      chk("cnt_all_ones", 32'(op_count), 32'(CNT_MOD - 1));
      issue(32'd2, 32'd2, 4'd0, 1'b1, mk(32'd4, 4'b0000, 1'b0));
      wait_rsp(2, "wrap");
      take("wrap");
      chk("cnt_wrapped", 32'(op_count), 32'd0);

      for (int i = 0; i < 8; i++) begin
         a = $urandom; b = $urandom;
         o = ops[$urandom_range(0, 11)];
         issue(a, b, o, 1'b1, alu_model(a, b, o));
         wait_rsp(2, "rand");
         take("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester has an operation.
REQ-005 req_ready  output  1  block accepts the operation this cycle.
REQ-006 req_op1  input  32  first operand.
REQ-007 req_op2  input  32  second operand.
REQ-008 req_oprt  input  4  ALU opcode.
REQ-009 alu_op1  output  32  operand 1 driven to ALU.
REQ-010 alu_op2  output  32  operand 2 driven to ALU.
REQ-011 alu_oprt  output  4  opcode driven to ALU.
REQ-012 alu_en  output  1  ALU enable.
REQ-013 alu_res  input  32  combinational ALU result.
REQ-014 alu_flag  input  11  registered ALU flags, bit 0 N, 1 Z, 2 C, 3 V.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  consumer takes response.
REQ-017 rsp_res  output  32  captured result.
REQ-018 rsp_flag  output  4  captured flags {V,C,Z,N}.
REQ-019 rsp_err  output  1  opcode unsupported.
REQ-020 busy  output  1  high whenever state is not IDLE.
REQ-021 op_count  output  CNT_W  completed responses, modulo 2^CNT_W.

Function
REQ-022 FSM states IDLE, EXEC, FLAG, RESP; one-hot or encoded is free.
REQ-023 req_ready = (state==IDLE) | (state==RESP & rsp_ready); accept = req_valid & req_ready.
REQ-024 On accept: latch req_op1/op2/oprt into operand registers; supported opcode -> EXEC, unsupported -> RESP.
REQ-025 Supported opcodes: 0000,0001,0100-1101; unsupported: 0010,0011,1110,1111.
REQ-026 alu_op1/op2/oprt always drive the latched registers; alu_en=1 only in EXEC and FLAG, else 0.
REQ-027 EXEC (1 cycle): at its closing edge capture alu_res into rsp_res; -> FLAG.
REQ-028 FLAG (1 cycle): at its closing edge capture alu_flag[3:0] into rsp_flag, rsp_err<=0; -> RESP.
REQ-029 Unsupported accept: rsp_res<=0x80000000, rsp_flag<=0, rsp_err<=1, direct to RESP; alu_en stays 0.
REQ-030 rsp_valid=1 exactly in RESP; rsp_res/rsp_flag/rsp_err stable while rsp_valid & ~rsp_ready.
REQ-031 Latency: rsp_valid rises 2 edges after a supported accept edge, 0 edges (next cycle) after unsupported.
REQ-032 RESP & rsp_ready: op_count+1 (wraps all-ones -> 0); if simultaneous accept -> EXEC/RESP per REQ-024, else -> IDLE.
REQ-033 Peak throughput: one supported op per 3 cycles via REQ-032 back-to-back path.
REQ-034 req_valid ignored when req_ready=0; no request buffering.

Reset
REQ-035 rst low at any time, any state: state IDLE, all output registers and operand registers 0, alu_en 0, rsp_valid 0, op_count 0, asynchronously.
REQ-036 In-flight operation at reset is discarded, never responded.
REQ-037 After rst rises, req_ready=1 in the first cycle.

Verification
REQ-038 ADD 5+3 -> rsp_res 0x00000008, rsp_flag 0000, rsp_err 0, rsp_valid 2 edges after accept.
REQ-039 SUB 3-5 -> rsp_res 0xFFFFFFFE, rsp_flag 0001 (N only).
REQ-040 ADD 0x7FFFFFFF+0x00000001 -> rsp_res 0x80000000, rsp_flag 1001 (V,N).
REQ-041 oprt 1110 -> rsp_err 1, rsp_res 0x80000000, rsp_flag 0, alu_en never 1, rsp_valid next cycle.
REQ-042 rsp_ready low 5 cycles -> response stable, req_ready 0; then rsp_ready with req_valid -> same-edge handshake + accept, op_count +1, next response 3 cycles later.
REQ-043 rst low during FLAG -> outputs 0 immediately, no response; op_count preset to all-ones then one response -> wraps to 0.
